uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial UART transmitter: takes a parallel byte on a one-cycle start strobe and shifts it out LSB-first.
- Frame on the tx line: start bit (0), NDATA data bits, optional parity, one stop bit (1).
- Bit timing comes from an internal bit-period counter that runs only while a frame is in progress.
- Sits between the host-side register/command logic and the serial pad; it is the transmit counterpart of the team's UART receiver.

Parameters:
- NDATA, 8, number of data bits per frame.
- BAUD_DIV, 5208, clk cycles per bit (50 MHz / 9600 baud); legal range >= 2.
- CNT_BITS, 13, width of the bit-period counter; must satisfy 2^CNT_BITS > BAUD_DIV-1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- tx_start  input  1  one-cycle request to send tx_data; accepted only in IDLE.
- tx_data  input  NDATA  byte to transmit; sampled on the accepting edge.
- tx  output  1  serial line, registered, idle high.
- tx_busy  output  1  high from the accepting edge until the frame completes.
- tx_done  output  1  one-cycle pulse marking end of frame.

Behaviour:
- Reset (async, reset=0): state=IDLE, tx=1, tx_busy=0, tx_done=0, shift register=0, bit counter=0, period counter=0.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: tx=1, tx_busy=0.
  - On an edge with tx_start=1, latch tx_data into the shift register and enter START; tx=0 and tx_busy=1 from that same edge.
  - Zero-cycle latency from request to start bit.
- Bit period: the counter clears on every state change and increments each cycle inside a state. A state lasts exactly BAUD_DIV cycles; it advances on the edge where counter == BAUD_DIV-1.
- START: tx=0 for BAUD_DIV cycles -> DATA.
- DATA: tx = shift_reg[0] for each bit. At the end of each bit period, shift right by 1 and increment the bit index. After bit NDATA-1 -> PARITY if enabled, else STOP. The bit index wraps to 0 on exit.
- STOP: tx=1 for BAUD_DIV cycles. On the exit edge: state=IDLE, tx_busy=0, tx_done=1 for exactly one cycle.
- Total frame: (NDATA+2)*BAUD_DIV cycles; (NDATA+3)*BAUD_DIV with parity.
- tx_start while tx_busy=1 is ignored; tx_data changes mid-frame do not affect the frame in progress.
- Back-to-back: tx_start asserted in the cycle tx_done=1 is accepted. The next start bit begins on that edge, with no idle bit between frames.
- Reset asserted mid-frame: frame is aborted immediately, outputs take reset values, and no tx_done is generated. After reset release the block is in IDLE.
- tx is glitch-free: driven from a flop, never decoded combinationally from state.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: PARITY state is inserted after DATA. tx = even parity (XOR of the latched data) for BAUD_DIV cycles. Frame length becomes NDATA+3 bits. Parity is computed from the latched byte, not the live tx_data.
- Not defined: no PARITY state and no parity logic; DATA goes directly to STOP.

Decomposition:
- Package uart_pkg holds:
  - state encoding typedef (IDLE, START, DATA, PARITY, STOP);
  - constants DEF_BAUD_DIV=5208, DEF_NDATA=8;
  - line-level constants LINE_IDLE=1, START_BIT=0, STOP_BIT=1.
- One sub-module: uart_baud_tick.
  - Parameterized by CNT_BITS and BAUD_DIV.
  - Inputs clk, reset, enable; output tick.
  - Counts while enable=1 and clears when enable=0; tick is high when count == BAUD_DIV-1.
  - The FSM drives enable=0 for one cycle on each state change to restart the period.

Test Plan (bench uses BAUD_DIV=4, NDATA=8):
- Reset idle: hold reset=0 then release, no tx_start -> tx=1, tx_busy=0, tx_done=0 for 100 cycles.
- Single byte 0xA5: pulse tx_start -> tx per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1. tx_busy high 40 cycles; one tx_done pulse on cycle 40.
- Busy rejection: send 0x3C, pulse tx_start with tx_data=0xFF at cycle 10 -> serialized byte is still 0x3C; exactly one tx_done.
- Back-to-back: send 0x00, assert tx_start with 0xFF in the tx_done cycle -> second start bit immediately follows the stop bit. 80 cycles total, two tx_done pulses.
- Reset mid-frame: send 0x55, drop reset at cycle 17 -> tx=1 and tx_busy=0 asynchronously, no tx_done. A later 0x81 transmits correctly.
- Parity (UART_TX_PARITY_EN defined): send 0x07 -> parity bit=1, 44-cycle frame. Send 0x03 -> parity bit=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter: FSM state encoding,
// default frame geometry and tx line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int DEF_BAUD_DIV = 5208;
  localparam int DEF_NDATA    = 8;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// Host-side transmit handshake plus serial line outputs of uart_tx.
// The slave modport is the transmitter; master is the host/pad side.
interface uart_tx_if #(
  parameter int NDATA = 8
);
  logic             tx_start;
  logic [NDATA-1:0] tx_data;
  logic             tx;
  logic             tx_busy;
  logic             tx_done;

  modport slave (
    input  tx_start,
    input  tx_data,
    output tx,
    output tx_busy,
    output tx_done
  );

  modport master (
    output tx_start,
    output tx_data,
    input  tx,
    input  tx_busy,
    input  tx_done
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts while enabled, clears when disabled, and flags
// the last cycle of a bit period.
module uart_baud_tick #(
  parameter int CNT_BITS = 13,
  parameter int BAUD_DIV = 5208
) (
  input  logic clk,
  input  logic reset,
  input  logic i_enable,
  output logic o_tick
);

  logic [CNT_BITS-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_tick = (r_cnt == CNT_BITS'(BAUD_DIV - 1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, NDATA data bits LSB-first, optional even
// parity (enabled by UART_TX_PARITY_EN), one stop bit. tx is driven from a flop.
//
//   state  | meaning
//   IDLE   | line high, waiting for tx_start
//   START  | driving the start bit
//   DATA   | shifting data bits out LSB-first
//   PARITY | driving even parity of the latched byte
//   STOP   | driving the stop bit, then pulse tx_done
module uart_tx
  import uart_pkg::*;
#(
  parameter int NDATA    = DEF_NDATA,
  parameter int BAUD_DIV = DEF_BAUD_DIV,
  parameter int CNT_BITS = 13
) (
  input  logic      clk,
  input  logic      reset,
  uart_tx_if.slave  bus
);

  localparam int IDX_W = (NDATA > 1) ? $clog2(NDATA) : 1;

  uart_state_e      r_state, w_state_nxt;
  logic [NDATA-1:0] r_shift, w_shift_nxt, w_shifted;
  logic [IDX_W-1:0] r_bit_idx, w_bit_idx_nxt;
  logic             r_tx, w_tx_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             w_tick;
  logic             w_baud_en;
`ifdef UART_TX_PARITY_EN
  logic             r_parity, w_parity_nxt;
`endif

  // Holding enable low on the tick edge restarts the period in the new state.
  assign w_baud_en = (r_state != IDLE) && !w_tick;

  uart_baud_tick #(
    .CNT_BITS (CNT_BITS),
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_tick (
    .clk      (clk),
    .reset    (reset),
    .i_enable (w_baud_en),
    .o_tick   (w_tick)
  );

  assign w_shifted = r_shift >> 1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_tx      <= LINE_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_tx      <= w_tx_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
`ifdef UART_TX_PARITY_EN
      r_parity  <= w_parity_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_idx_nxt = r_bit_idx;
    w_tx_nxt      = r_tx;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_parity_nxt  = r_parity;
`endif

    case (r_state)
      IDLE: begin
        w_tx_nxt   = LINE_IDLE;
        w_busy_nxt = 1'b0;
        if (bus.tx_start) begin
          w_shift_nxt = bus.tx_data;
          w_state_nxt = START;
          w_tx_nxt    = START_BIT;
          w_busy_nxt  = 1'b1;
`ifdef UART_TX_PARITY_EN
          w_parity_nxt = ^bus.tx_data;
`endif
        end
      end

      START: begin
        if (w_tick) begin
          w_state_nxt = DATA;
          w_tx_nxt    = r_shift[0];
        end
      end

      DATA: begin
        if (w_tick) begin
          w_shift_nxt = w_shifted;
          if (r_bit_idx == IDX_W'(NDATA - 1)) begin
            w_bit_idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
            w_state_nxt   = PARITY;
            w_tx_nxt      = r_parity;
`else
            w_state_nxt   = STOP;
            w_tx_nxt      = STOP_BIT;
`endif
          end else begin
            w_bit_idx_nxt = r_bit_idx + 1'b1;
            w_tx_nxt      = w_shifted[0];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_tick) begin
          w_state_nxt = STOP;
          w_tx_nxt    = STOP_BIT;
        end
      end
`endif

      STOP: begin
        if (w_tick) begin
          w_state_nxt = IDLE;
          w_tx_nxt    = LINE_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = LINE_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign bus.tx      = r_tx;
  assign bus.tx_busy = r_busy;
  assign bus.tx_done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx with BAUD_DIV=4, NDATA=8; define
// UART_TX_PARITY_EN to also exercise the parity frame.
module tb_uart_tx;

  localparam int NDATA = 8;
  localparam int BDIV  = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = NDATA + 3;
`else
  localparam int NB = NDATA + 2;
`endif
  localparam int FRAME_CYC = NB * BDIV;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   n_done;

  uart_tx_if #(.NDATA(NDATA)) u_if ();

  uart_tx #(
    .NDATA    (NDATA),
    .BAUD_DIV (BDIV),
    .CNT_BITS (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (u_if.tx_done === 1'b1) n_done++;

  function automatic logic exp_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= NDATA) return d[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == NDATA + 1) return ^d;
`endif
    return 1'b1;
  endfunction

  // Assumes caller is at a negedge; pulses tx_start over the next posedge and
  // returns at the negedge of frame cycle 0.
  task automatic pulse_start(input logic [7:0] d);
    u_if.tx_start = 1'b1;
    u_if.tx_data  = d;
    @(negedge clk);
    u_if.tx_start = 1'b0;
  endtask

  // Walks a frame from cycle 0, optionally injecting a rejected start or an
  // async reset. Ends at the negedge of the tx_done cycle (or after abort).
  task automatic check_frame(input logic [7:0] d, input string name,
                             input int inject_at, input int abort_at);
    for (int i = 0; i < FRAME_CYC; i++) begin
      if (i == abort_at) begin
        reset = 1'b0;
        #1;
        checks++;
        if (u_if.tx !== 1'b1 || u_if.tx_busy !== 1'b0 || u_if.tx_done !== 1'b0) begin
          errors++;
          $display("FAIL %s_abort: tx=%b busy=%b done=%b, required tx=1 busy=0 done=0",
                   name, u_if.tx, u_if.tx_busy, u_if.tx_done);
        end
        return;
      end
      if (i == inject_at) begin
        u_if.tx_start = 1'b1;
        u_if.tx_data  = 8'hFF;
      end else if (i == inject_at + 1) begin
        u_if.tx_start = 1'b0;
      end
      checks++;
      if (u_if.tx !== exp_bit(d, i / BDIV) || u_if.tx_busy !== 1'b1 || u_if.tx_done !== 1'b0) begin
        errors++;
        $display("FAIL %s_cyc%0d: tx=%b busy=%b done=%b, required tx=%b busy=1 done=0",
                 name, i, u_if.tx, u_if.tx_busy, u_if.tx_done, exp_bit(d, i / BDIV));
      end
      @(negedge clk);
    end
    checks++;
    if (u_if.tx_done !== 1'b1 || u_if.tx_busy !== 1'b0 || u_if.tx !== 1'b1) begin
      errors++;
      $display("FAIL %s_end: tx=%b busy=%b done=%b, required tx=1 busy=0 done=1",
               name, u_if.tx, u_if.tx_busy, u_if.tx_done);
    end
  endtask

  task automatic check_idle(input string name, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      checks++;
      if (u_if.tx !== 1'b1 || u_if.tx_busy !== 1'b0 || u_if.tx_done !== 1'b0) begin
        errors++;
        $display("FAIL %s_cyc%0d: tx=%b busy=%b done=%b, required tx=1 busy=0 done=0",
                 name, i, u_if.tx, u_if.tx_busy, u_if.tx_done);
      end
      @(negedge clk);
    end
  endtask

  task automatic check_done_count(input string name, input int base, input int want);
    checks++;
    if (n_done - base !== want) begin
      errors++;
      $display("FAIL %s_done_count: got %0d pulses, required %0d", name, n_done - base, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset_held", 2);
    reset = 1'b1;
    check_idle("reset_idle", 100);
  endtask

  task automatic test_single();
    int base;
    base = n_done;
    pulse_start(8'hA5);
    check_frame(8'hA5, "single_a5", -1, -1);
    @(negedge clk);
    check_idle("single_after", 4);
    check_done_count("single", base, 1);
  endtask

  task automatic test_busy_reject();
    int base;
    base = n_done;
    pulse_start(8'h3C);
    check_frame(8'h3C, "busy_3c", 10, -1);
    @(negedge clk);
    check_idle("busy_after", 10);
    check_done_count("busy", base, 1);
  endtask

  task automatic test_back_to_back();
    int base;
    base = n_done;
    pulse_start(8'h00);
    check_frame(8'h00, "b2b_first", -1, -1);
    pulse_start(8'hFF);
    check_frame(8'hFF, "b2b_second", -1, -1);
    @(negedge clk);
    check_idle("b2b_after", 4);
    check_done_count("b2b", base, 2);
  endtask

  task automatic test_reset_mid_frame();
    int base;
    base = n_done;
    pulse_start(8'h55);
    check_frame(8'h55, "abort_55", -1, 17);
    repeat (2) @(negedge clk);
    check_idle("abort_held", 2);
    reset = 1'b1;
    check_idle("abort_release", 10);
    check_done_count("abort", base, 0);
    pulse_start(8'h81);
    check_frame(8'h81, "after_abort_81", -1, -1);
    @(negedge clk);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    pulse_start(8'h07);
    check_frame(8'h07, "parity_07", -1, -1);
    @(negedge clk);
    pulse_start(8'h03);
    check_frame(8'h03, "parity_03", -1, -1);
    @(negedge clk);
  endtask
`endif

  initial begin
    checks        = 0;
    errors        = 0;
    n_done        = 0;
    reset         = 1'b0;
    u_if.tx_start = 1'b0;
    u_if.tx_data  = '0;
    test_reset();
    test_single();
    test_busy_reject();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
